// File: rtl/accum_sequencer.sv
// Job sequencer for the 2-column double-buffered accumulator: steps clear/mode/buffer
// select through K passes per output tile and hands filled buffers to the drain.
module accum_sequencer #(
    parameter int CNT_W     = 8,
    parameter int ALIGN_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_rows,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    input  logic [CNT_W-1:0] cfg_out_tiles,
    input  logic             mmu_valid,
    input  logic             drain_ack,
    output logic             acc_clear,
    output logic             acc_enable,
    output logic             acc_addr_sel,
    output logic             mmu_stall,
    output logic             buf_ready,
    output logic             buf_ready_sel,
    output logic             busy,
    output logic             done,
    output logic             err_overrun
);

    // Handshakes: the MMU may assert mmu_valid only while mmu_stall is low (a beat under
    // stall is flagged, never counted); buf_ready announces one filled buffer, and each
    // drain_ack frees the oldest filled buffer whenever at least one is full.

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_BUF_WAIT,
        S_DRAIN_WAIT
    } state_t;

    localparam int FL_W = $clog2(ALIGN_LAT + 1) + 1;
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(ALIGN_LAT);

    state_t           state;
    logic [CNT_W-1:0] rows_q, k_tiles_q, out_tiles_q;
    logic [CNT_W-1:0] row, k, tile;
    logic [FL_W-1:0]  flush_cnt;
    logic [1:0]       buf_full;
    logic [1:0]       buf_full_nxt;
    logic             oldest;

    logic ack_ok, flush_end, last_pass, fill, cfg_zero;

    assign ack_ok    = drain_ack && (buf_full != 2'b00);
    assign flush_end = (state == S_FLUSH) && (flush_cnt == FLUSH_LAST);
    assign last_pass = (k == k_tiles_q - CNT_W'(1));
    assign fill      = flush_end && last_pass;
    assign cfg_zero  = (cfg_rows == '0) || (cfg_k_tiles == '0) || (cfg_out_tiles == '0);

    // A same-cycle ack and completion both land: free the oldest, mark the new one.
    always_comb begin
        buf_full_nxt = buf_full;
        if (ack_ok) buf_full_nxt[oldest] = 1'b0;
        if (fill)   buf_full_nxt[acc_addr_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            rows_q        <= '0;
            k_tiles_q     <= '0;
            out_tiles_q   <= '0;
            row           <= '0;
            k             <= '0;
            tile          <= '0;
            flush_cnt     <= '0;
            buf_full      <= 2'b00;
            oldest        <= 1'b0;
            acc_clear     <= 1'b0;
            acc_enable    <= 1'b0;
            acc_addr_sel  <= 1'b0;
            mmu_stall     <= 1'b1;
            buf_ready     <= 1'b0;
            buf_ready_sel <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            acc_clear <= 1'b0;
            buf_ready <= 1'b0;
            done      <= 1'b0;
            buf_full  <= buf_full_nxt;
            if (ack_ok) oldest <= ~oldest;
            if (mmu_valid && mmu_stall) err_overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_zero) begin
                            done <= 1'b1;
                        end else begin
                            rows_q       <= cfg_rows;
                            k_tiles_q    <= cfg_k_tiles;
                            out_tiles_q  <= cfg_out_tiles;
                            err_overrun  <= 1'b0;
                            acc_addr_sel <= 1'b0;
                            acc_clear    <= 1'b1;
                            busy         <= 1'b1;
                            oldest       <= 1'b0;
                            state        <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    row        <= '0;
                    k          <= '0;
                    tile       <= '0;
                    acc_enable <= 1'b0;
                    mmu_stall  <= 1'b0;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    if (mmu_valid) begin
                        row <= row + CNT_W'(1);
                        if (row == rows_q - CNT_W'(1)) begin
                            mmu_stall <= 1'b1;
                            flush_cnt <= '0;
                            state     <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Mode and select stay put until the last aligned beat is written.
                    if (!flush_end) begin
                        flush_cnt <= flush_cnt + FL_W'(1);
                    end else begin
                        row <= '0;
                        if (!last_pass) begin
                            k          <= k + CNT_W'(1);
                            acc_enable <= 1'b1;
                            mmu_stall  <= 1'b0;
                            state      <= S_RUN;
                        end else begin
                            buf_ready     <= 1'b1;
                            buf_ready_sel <= acc_addr_sel;
                            k             <= '0;
                            tile          <= tile + CNT_W'(1);
                            acc_enable    <= 1'b0;
                            if (tile + CNT_W'(1) == out_tiles_q) begin
                                state <= S_DRAIN_WAIT;
                            end else begin
                                acc_addr_sel <= ~acc_addr_sel;
                                if (buf_full_nxt[~acc_addr_sel]) begin
                                    state <= S_BUF_WAIT;
                                end else begin
                                    mmu_stall <= 1'b0;
                                    state     <= S_RUN;
                                end
                            end
                        end
                    end
                end
                S_BUF_WAIT: begin
                    if (!buf_full[acc_addr_sel]) begin
                        mmu_stall <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_DRAIN_WAIT: begin
                    if (buf_full == 2'b00) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Control FSM for the 2-column double-buffered accumulator (align stage + 2-buffer memory).
- For each job it drives the accumulator's clear, accumulate/overwrite mode and buffer select across K partial-sum passes and multiple output tiles.
- Throttles the MMU with a stall output and hands completed buffers to the downstream drain (activation/writeback) with a ready/ack handshake.

Parameters:
- CNT_W, 8, width of the job configuration fields and internal counters.
- ALIGN_LAT, 2, cycles from an MMU valid to the accumulator write; the sequencer must not change mode or select until that many cycles have passed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- cfg_rows  in  CNT_W  MMU valid beats per pass.
- cfg_k_tiles  in  CNT_W  passes accumulated into one buffer.
- cfg_out_tiles  in  CNT_W  output tiles (buffer fills) per job.
- mmu_valid  in  1  MMU column data valid; same signal as the accumulator valid_in.
- drain_ack  in  1  downstream has consumed the oldest full buffer.
- acc_clear  out  1  to accumulator clear.
- acc_enable  out  1  to accumulator mode: 0 = overwrite, 1 = add.
- acc_addr_sel  out  1  to accumulator buffer select.
- mmu_stall  out  1  MMU must not assert mmu_valid.
- buf_ready  out  1  one-cycle pulse: a buffer is complete.
- buf_ready_sel  out  1  which buffer buf_ready refers to.
- busy  out  1  a job is in progress (state is not IDLE).
- done  out  1  one-cycle pulse at job end.
- err_overrun  out  1  sticky flag; cleared by start or reset.

Behaviour:
- All outputs are registered.
- Reset values: acc_clear=0, acc_enable=0, acc_addr_sel=0, mmu_stall=1, buf_ready=0, buf_ready_sel=0, busy=0, done=0, err_overrun=0.
- Reset also sets state=IDLE, clears all counters and sets buf_full=2'b00.
- Reset mid-job aborts the job immediately: no done pulse, no buf_ready pulse.
- Configuration is latched on start. Changes to cfg_* during a job are ignored.
- Zero configuration: if start arrives with any cfg field equal to 0, pulse done next cycle, stay in IDLE and generate no accumulator activity.
- IDLE: mmu_stall=1. On start, go to CLEAR, set err_overrun=0, set acc_addr_sel=0.
- CLEAR (1 cycle): acc_clear=1, then go to RUN with k=0, tile=0, row=0.
- RUN:
  - mmu_stall=0.
  - acc_enable=0 when k==0, else 1.
  - Each mmu_valid increments row.
  - The beat where row==cfg_rows-1 is accepted. On the same edge, mmu_stall goes to 1 and the FSM goes to FLUSH.
- FLUSH:
  - mmu_stall=1.
  - Wait ALIGN_LAT+1 cycles with acc_enable and acc_addr_sel held.
  - Then set row=0. If k<cfg_k_tiles-1: increment k and return to RUN.
  - Otherwise:
    - set buf_full[acc_addr_sel]=1;
    - pulse buf_ready with buf_ready_sel=acc_addr_sel;
    - set k=0 and increment tile.
  - If tile is now cfg_out_tiles, go to DRAIN_WAIT.
  - Otherwise toggle acc_addr_sel and go to RUN if the new buffer is not full, else go to BUF_WAIT.
- BUF_WAIT: mmu_stall=1. Go to RUN on the cycle after buf_full[acc_addr_sel] clears.
- DRAIN_WAIT: mmu_stall=1. When buf_full==0, pulse done and go to IDLE.
- Buffer freeing:
  - drain_ack clears buf_full of the oldest full buffer. Buffers complete strictly alternately, so the oldest is tracked with a 1-bit pointer.
  - drain_ack with buf_full==0 is ignored.
  - When drain_ack and buffer completion occur in the same cycle, both updates apply: clear the old buffer, set the new one.
- Overrun: mmu_valid while mmu_stall=1 sets err_overrun. The beat is not counted and the FSM is unaffected.
- start while busy is ignored.
- Counter widths are CNT_W. Because cfg values are at least 1, counters never wrap.

Test Plan:
- reset, then start with rows=4, k=1, out=1, 4 mmu_valid beats:
  - acc_clear is high for one cycle;
  - acc_enable=0 throughout;
  - buf_ready pulses with sel=0 exactly ALIGN_LAT+1 cycles after the 4th beat;
  - after drain_ack, done pulses and busy drops.
- rows=2, k=3, out=1: acc_enable=0 on pass 0 and 1 on passes 1–2; mmu_stall is high for 3 cycles between passes; a single buf_ready (sel=0).
- rows=2, k=1, out=3, drain_ack withheld:
  - buffers 0 then 1 complete, then the FSM stalls in BUF_WAIT;
  - drain_ack releases buffer 0;
  - tile 3 completes with buf_ready_sel=0;
  - done arrives only after two more acks.
- drain_ack in the same cycle as buf_ready: buf_full transitions correctly and no deadlock occurs. Also drive mmu_valid during FLUSH: err_overrun=1 and the row count is unchanged.
- start with cfg_k_tiles=0: done next cycle, acc_clear never asserts, busy stays 0.
- reset asserted mid-RUN: all outputs return to reset values the next cycle, with no done pulse; a new start then runs normally.
